// File: rtl/uart_pkg.sv
// Shared constants for the pet controller's serial command path:
// command codes, ASCII characters, FSM encodings and letter decoding.
package uart_pkg;

   localparam logic [2:0] CMD_NONE   = 3'd0;
   localparam logic [2:0] CMD_FEED   = 3'd1;
   localparam logic [2:0] CMD_PLAY   = 3'd2;
   localparam logic [2:0] CMD_CLEAN  = 3'd3;
   localparam logic [2:0] CMD_SLEEP  = 3'd4;
   localparam logic [2:0] CMD_WAKE   = 3'd5;
   localparam logic [2:0] CMD_STATUS = 3'd6;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_SP = 8'h20;

   typedef enum logic [2:0] {
      R_IDLE  = 3'd0,
      R_START = 3'd1,
      R_DATA  = 3'd2,
      R_STOP  = 3'd3,
      R_BREAK = 3'd4
   } rx_state_t;

   typedef enum logic [1:0] {
      P_IDLE    = 2'd0,
      P_ARG     = 2'd1,
      P_END     = 2'd2,
      P_DISCARD = 2'd3
   } parse_state_t;

   // Maps a command letter (either case) or '?' to its code; CMD_NONE otherwise.
   function automatic logic [2:0] cmd_of(input logic [7:0] c);
      logic [2:0] code;
      case (c)
         "F", "f": code = CMD_FEED;
         "P", "p": code = CMD_PLAY;
         "C", "c": code = CMD_CLEAN;
         "S", "s": code = CMD_SLEEP;
         "W", "w": code = CMD_WAKE;
         "?":      code = CMD_STATUS;
         default:  code = CMD_NONE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART byte receiver: 2-FF synchroniser, mid-bit sampling FSM,
// framed-byte and framing-error strobes.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int DELAY_FRAMES = 234
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err,
   output logic [2:0] dbg_rx_state
);

   localparam int CW = $clog2(DELAY_FRAMES) + 1;
   localparam logic [CW-1:0] HALF_M1 = CW'(DELAY_FRAMES / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(DELAY_FRAMES - 1);

   rx_state_t     r_state;
   logic          r_sync1;
   logic          r_sync2;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_byte_valid;
   logic [7:0]    r_byte_data;
   logic          r_frame_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= R_IDLE;
         r_sync1      <= 1'b1;
         r_sync2      <= 1'b1;
         r_cnt        <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_byte_valid <= 1'b0;
         r_byte_data  <= '0;
         r_frame_err  <= 1'b0;
      end else begin
         r_sync1      <= uart_rx;
         r_sync2      <= r_sync1;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         case (r_state)
            R_IDLE: begin
               if (!r_sync2) begin
                  r_state <= R_START;
                  r_cnt   <= '0;
               end
            end
            R_START: begin
               if (r_cnt == HALF_M1) begin
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  // A line that is high again at mid start bit was only a glitch.
                  r_state   <= r_sync2 ? R_IDLE : R_DATA;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            R_DATA: begin
               if (r_cnt == FULL_M1) begin
                  r_cnt   <= '0;
                  r_shift <= {r_sync2, r_shift[7:1]};
                  if (r_bit_idx == 3'd7) r_state   <= R_STOP;
                  else                   r_bit_idx <= r_bit_idx + 3'd1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            R_STOP: begin
               if (r_cnt == FULL_M1) begin
                  r_cnt <= '0;
                  if (r_sync2) begin
                     r_byte_valid <= 1'b1;
                     r_byte_data  <= r_shift;
                     r_state      <= R_IDLE;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= R_BREAK;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            R_BREAK: begin
               if (r_sync2) r_state <= R_IDLE;
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   assign byte_valid   = r_byte_valid;
   assign byte_data    = r_byte_data;
   assign frame_err    = r_frame_err;
   assign dbg_rx_state = r_state;

endmodule

// File: rtl/uart_cmd_rx.sv
// Host command receiver: turns UART bytes into validated one-cycle
// command strobes for lines of the form <letter>[<digit>]<CR|LF>.
module uart_cmd_rx
   import uart_pkg::*;
#(
   parameter int DELAY_FRAMES = 234
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err,
   output logic       cmd_valid,
   output logic [2:0] cmd_code,
   output logic [3:0] cmd_arg,
   output logic       cmd_err,
   output logic [2:0] dbg_rx_state,
   output logic [1:0] dbg_parse_state
);

   logic       w_byte_valid;
   logic [7:0] w_byte_data;
   logic       w_frame_err;
   logic [2:0] w_code;
   logic       w_term;
   logic       w_digit;
   logic       w_space;

   uart_rx_core #(.DELAY_FRAMES(DELAY_FRAMES)) u_rx (
      .clk          (clk),
      .rst_n        (rst_n),
      .uart_rx      (uart_rx),
      .byte_valid   (w_byte_valid),
      .byte_data    (w_byte_data),
      .frame_err    (w_frame_err),
      .dbg_rx_state (dbg_rx_state)
   );

   assign w_code  = cmd_of(w_byte_data);
   assign w_term  = (w_byte_data == ASCII_CR) || (w_byte_data == ASCII_LF);
   assign w_digit = (w_byte_data >= 8'h30) && (w_byte_data <= 8'h39);
   assign w_space = (w_byte_data == ASCII_SP);

   parse_state_t r_pstate;
   logic [2:0]   r_code;
   logic [3:0]   r_arg;
   logic         r_cmd_valid;
   logic [2:0]   r_cmd_code;
   logic [3:0]   r_cmd_arg;
   logic         r_cmd_err;

   // r_code/r_arg track the line in progress; r_cmd_* only change on a completed command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pstate    <= P_IDLE;
         r_code      <= '0;
         r_arg       <= '0;
         r_cmd_valid <= 1'b0;
         r_cmd_code  <= '0;
         r_cmd_arg   <= '0;
         r_cmd_err   <= 1'b0;
      end else begin
         r_cmd_valid <= 1'b0;
         r_cmd_err   <= 1'b0;
         if (w_byte_valid && !w_space) begin
            case (r_pstate)
               P_IDLE: begin
                  if (w_code != CMD_NONE) begin
                     r_code   <= w_code;
                     r_arg    <= 4'd1;
                     r_pstate <= P_ARG;
                  end else if (!w_term) begin
                     r_cmd_err <= 1'b1;
                     r_pstate  <= P_DISCARD;
                  end
               end
               P_ARG: begin
                  if (w_digit) begin
                     r_arg    <= w_byte_data[3:0];
                     r_pstate <= P_END;
                  end else if (w_term) begin
                     r_cmd_valid <= 1'b1;
                     r_cmd_code  <= r_code;
                     r_cmd_arg   <= r_arg;
                     r_pstate    <= P_IDLE;
                  end else begin
                     r_cmd_err <= 1'b1;
                     r_pstate  <= P_DISCARD;
                  end
               end
               P_END: begin
                  if (w_term) begin
                     r_cmd_valid <= 1'b1;
                     r_cmd_code  <= r_code;
                     r_cmd_arg   <= r_arg;
                     r_pstate    <= P_IDLE;
                  end else begin
                     r_cmd_err <= 1'b1;
                     r_pstate  <= P_DISCARD;
                  end
               end
               P_DISCARD: begin
                  if (w_term) r_pstate <= P_IDLE;
               end
               default: r_pstate <= P_IDLE;
            endcase
         end else if (w_frame_err && (r_pstate == P_ARG || r_pstate == P_END)) begin
            r_cmd_err <= 1'b1;
            r_pstate  <= P_DISCARD;
         end
      end
   end

   assign byte_valid      = w_byte_valid;
   assign byte_data       = w_byte_data;
   assign frame_err       = w_frame_err;
   assign cmd_valid       = r_cmd_valid;
   assign cmd_code        = r_cmd_code;
   assign cmd_arg         = r_cmd_arg;
   assign cmd_err         = r_cmd_err;
   assign dbg_parse_state = r_pstate;

endmodule
